trap_sequencer: RTL
===================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath and CSR width.
REQ-002 SHALL have parameter WFI_TIMEOUT, default 8, cycles in WFI before a TW timeout fires (legal range 1..255).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 TrapReq  in  1  trap (exception or interrupt) taken this cycle.
REQ-006 Interrupt  in  1  trap is an interrupt; qualifies TrapReq.
REQ-007 Delegate  in  1  trap goes to supervisor; else machine.
REQ-008 Cause  in  4  trap cause code.
REQ-009 PC  in  XLEN  PC of trapping instruction.
REQ-010 Tval  in  XLEN  trap value.
REQ-011 MTVEC, STVEC  in  XLEN each  trap vector CSRs; [1:0]=mode.
REQ-012 RetReq  in  1  mret or sret taken; RetIsS  in  1  high for sret.
REQ-013 MEPC, SEPC  in  XLEN each  return targets.
REQ-014 WfiReq  in  1  wfi reached M stage; IntPending  in  1  any pending enabled interrupt; StatusTW  in  1  mstatus.TW.
REQ-015 Stall  out  1  freeze pipeline.
REQ-016 CsrWe  out  1  CSR write strobe; CsrSel  out  3  0=EPC 1=CAUSE 2=TVAL 3=STATUS_TRAP 4=STATUS_RET; CsrS  out  1  target S-mode CSR copy.
REQ-017 CsrWData  out  XLEN  CSR write data.
REQ-018 Redirect  out  1  fetch redirect strobe; RedirectPC  out  XLEN  target.
REQ-019 WfiTimeout  out  1  one-cycle pulse, WFI timed out under TW.

Function
REQ-020 SHALL implement states IDLE, EPC, CAUSE, TVAL, STATUS, RSTATUS, REDIR, WFI.
REQ-021 In IDLE, priority SHALL be TrapReq > RetReq > WfiReq; lower requests in the same cycle are dropped.
REQ-022 IDLE+TrapReq SHALL latch PC, Tval, Cause, Interrupt, Delegate and the selected tvec (STVEC if Delegate else MTVEC), then go to EPC.
REQ-023 Trap path SHALL be EPC->CAUSE->TVAL->STATUS->REDIR->IDLE, one cycle each, with CsrWe=1 and CsrSel=0,1,2,3 in the first four states.
REQ-024 CsrWData SHALL be latched PC in EPC, {Interrupt, zeros, Cause} with Interrupt at bit XLEN-1 in CAUSE, latched Tval in TVAL, and 0 in STATUS/RSTATUS.
REQ-025 CsrS SHALL equal latched Delegate on the trap path and latched RetIsS on the return path.
REQ-026 REDIR SHALL assert Redirect for exactly one cycle.
REQ-027 Trap RedirectPC SHALL be {tvec[XLEN-1:2],2'b00} + (Cause<<2) when tvec[1:0]==01 and Interrupt, else {tvec[XLEN-1:2],2'b00}; the addition wraps modulo 2^XLEN.
REQ-028 IDLE+RetReq SHALL latch RetIsS and the target (SEPC if RetIsS else MEPC), then go RSTATUS (CsrWe=1, CsrSel=4) -> REDIR -> IDLE with RedirectPC = target.
REQ-029 IDLE+WfiReq SHALL go to WFI and clear the 8-bit wait counter.
REQ-030 In WFI, TrapReq SHALL take priority and enter the trap path exactly as from IDLE.
REQ-031 In WFI, otherwise IntPending SHALL return to IDLE next cycle.
REQ-032 In WFI, otherwise when StatusTW=1 and counter==WFI_TIMEOUT-1, WfiTimeout SHALL pulse and the state SHALL return to IDLE.
REQ-033 In WFI, otherwise the counter SHALL increment, saturating at 255; with StatusTW=0 the block waits indefinitely.
REQ-034 Stall SHALL be 1 whenever state!=IDLE, and in IDLE whenever TrapReq, RetReq or WfiReq is high.
REQ-035 Requests arriving in states other than IDLE and WFI SHALL be ignored.
REQ-036 Trap latency SHALL be a request in cycle N producing Redirect in cycle N+5; return latency is N+2.

Reset
REQ-037 Reset SHALL force IDLE, clear the counter and all latches, and drive Stall, CsrWe, CsrSel, CsrS, CsrWData, Redirect, RedirectPC and WfiTimeout to 0.
REQ-038 Reset SHALL take priority over every request, including mid-sequence; after reset no partial sequence resumes.

Verification
REQ-039 Trap, MTVEC=0x8000_0001, Interrupt=1, Cause=7, Delegate=0 -> CSR writes EPC, CAUSE=0x8000_0000_0000_0007, TVAL, STATUS; Redirect at N+5 with PC 0x8000_001C.
REQ-040 Exception, STVEC=0x4000_0001, Cause=2, Delegate=1 -> CsrS=1 throughout, RedirectPC=0x4000_0000 (no vectoring).
REQ-041 sret, SEPC=0x1234 -> RSTATUS with CsrS=1, Redirect at N+2 with PC 0x1234.
REQ-042 WFI, StatusTW=1, WFI_TIMEOUT=8, no interrupt -> WfiTimeout pulses 8 cycles after entry, then IDLE; with StatusTW=0 it stalls 300 cycles until IntPending, then IDLE.
REQ-043 TrapReq+RetReq+WfiReq together in IDLE -> trap path only; TrapReq during WFI -> trap path, no WfiTimeout.
REQ-044 Reset asserted in TVAL -> next cycle IDLE, all outputs 0, Stall=0.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap/return/WFI sequencer: walks the CSR write sequence for traps and returns,
// then redirects fetch; also supervises WFI with an optional TW timeout.
module trap_sequencer #(
    parameter int XLEN        = 64,
    parameter int WFI_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            TrapReq,
    input  logic            Interrupt,
    input  logic            Delegate,
    input  logic [3:0]      Cause,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Tval,
    input  logic [XLEN-1:0] MTVEC,
    input  logic [XLEN-1:0] STVEC,
    input  logic            RetReq,
    input  logic            RetIsS,
    input  logic [XLEN-1:0] MEPC,
    input  logic [XLEN-1:0] SEPC,
    input  logic            WfiReq,
    input  logic            IntPending,
    input  logic            StatusTW,
    output logic            Stall,
    output logic            CsrWe,
    output logic [2:0]      CsrSel,
    output logic            CsrS,
    output logic [XLEN-1:0] CsrWData,
    output logic            Redirect,
    output logic [XLEN-1:0] RedirectPC,
    output logic            WfiTimeout
);

    typedef enum logic [2:0] {
        IDLE, EPC, CAUSE, TVAL, STATUS, RSTATUS, REDIR, WFI
    } state_t;

    localparam logic [2:0] SEL_EPC         = 3'd0;
    localparam logic [2:0] SEL_CAUSE       = 3'd1;
    localparam logic [2:0] SEL_TVAL        = 3'd2;
    localparam logic [2:0] SEL_STATUS_TRAP = 3'd3;
    localparam logic [2:0] SEL_STATUS_RET  = 3'd4;

    state_t          state, stateNext;
    logic [7:0]      waitCount;
    logic [XLEN-1:0] pcQ, tvalQ, tvecQ, retTargetQ;
    logic [3:0]      causeQ;
    logic            intQ, delegQ, retIsSQ, isRetQ;

    logic            takeTrap, takeRet, takeWfi, timeoutHit;
    logic [XLEN-1:0] trapBase, trapTarget;

    // Request arbitration: trap beats return beats wfi; only IDLE and WFI listen.
    assign takeTrap   = (state == IDLE || state == WFI) && TrapReq;
    assign takeRet    = (state == IDLE) && !TrapReq && RetReq;
    assign takeWfi    = (state == IDLE) && !TrapReq && !RetReq && WfiReq;
    assign timeoutHit = (state == WFI) && !TrapReq && !IntPending && StatusTW
                        && (waitCount == 8'(WFI_TIMEOUT - 1));

    assign trapBase   = {tvecQ[XLEN-1:2], 2'b00};
    assign trapTarget = (tvecQ[1:0] == 2'b01 && intQ)
                        ? trapBase + (XLEN'(causeQ) << 2)
                        : trapBase;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            waitCount  <= '0;
            pcQ        <= '0;
            tvalQ      <= '0;
            tvecQ      <= '0;
            retTargetQ <= '0;
            causeQ     <= '0;
            intQ       <= 1'b0;
            delegQ     <= 1'b0;
            retIsSQ    <= 1'b0;
            isRetQ     <= 1'b0;
        end else begin
            state <= stateNext;
            if (takeTrap) begin
                pcQ    <= PC;
                tvalQ  <= Tval;
                causeQ <= Cause;
                intQ   <= Interrupt;
                delegQ <= Delegate;
                tvecQ  <= Delegate ? STVEC : MTVEC;
                isRetQ <= 1'b0;
            end
            if (takeRet) begin
                retIsSQ    <= RetIsS;
                retTargetQ <= RetIsS ? SEPC : MEPC;
                isRetQ     <= 1'b1;
            end
            if (takeWfi)
                waitCount <= '0;
            else if (state == WFI && waitCount != 8'hFF)
                waitCount <= waitCount + 8'd1;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        stateNext  = state;
        Stall      = 1'b1;
        CsrWe      = 1'b0;
        CsrSel     = SEL_EPC;
        CsrS       = isRetQ ? retIsSQ : delegQ;
        CsrWData   = '0;
        Redirect   = 1'b0;
        RedirectPC = '0;
        WfiTimeout = 1'b0;

        case (state)
            IDLE: begin
                Stall = TrapReq || RetReq || WfiReq;
                CsrS  = 1'b0;
                if (takeTrap)     stateNext = EPC;
                else if (takeRet) stateNext = RSTATUS;
                else if (takeWfi) stateNext = WFI;
            end
            EPC: begin
                CsrWe     = 1'b1;
                CsrSel    = SEL_EPC;
                CsrWData  = pcQ;
                stateNext = CAUSE;
            end
            CAUSE: begin
                CsrWe     = 1'b1;
                CsrSel    = SEL_CAUSE;
                CsrWData  = {intQ, {(XLEN-5){1'b0}}, causeQ};
                stateNext = TVAL;
            end
            TVAL: begin
                CsrWe     = 1'b1;
                CsrSel    = SEL_TVAL;
                CsrWData  = tvalQ;
                stateNext = STATUS;
            end
            STATUS: begin
                CsrWe     = 1'b1;
                CsrSel    = SEL_STATUS_TRAP;
                stateNext = REDIR;
            end
            RSTATUS: begin
                CsrWe     = 1'b1;
                CsrSel    = SEL_STATUS_RET;
                stateNext = REDIR;
            end
            REDIR: begin
                Redirect   = 1'b1;
                RedirectPC = isRetQ ? retTargetQ : trapTarget;
                stateNext  = IDLE;
            end
            WFI: begin
                CsrS = 1'b0;
                if (takeTrap) begin
                    stateNext = EPC;
                end else if (IntPending) begin
                    stateNext = IDLE;
                end else if (timeoutHit) begin
                    WfiTimeout = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Outputs read as quiet for the whole reset cycle, not just afterwards.
        if (reset) begin
            Stall      = 1'b0;
            CsrWe      = 1'b0;
            CsrSel     = SEL_EPC;
            CsrS       = 1'b0;
            CsrWData   = '0;
            Redirect   = 1'b0;
            RedirectPC = '0;
            WfiTimeout = 1'b0;
        end
    end

endmodule
